reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb_pkg.sv | 11 +
 rtl/reg_file_sb_scoreboard.sv | 54 +++++
 rtl/reg_file_sb.sv | 86 ++++++++
 tb/tb_reg_file_sb.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared sizing for the register file and its scoreboard.
// Data width, register count, address width and the register address type.
package pkg_parameters;

    localparam int XLEN    = 32;
    localparam int NUM_REG = 32;
    localparam int AW      = $clog2(NUM_REG);

    typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: one pending bit per architectural register.
// Priority at each edge, lowest to highest:
//   hold < write clear < alloc set < flush < reset.
// Bit 0 is hard-wired to 0.
module reg_scoreboard
    import pkg_parameters::*;
#(
    parameter int NUM_REG = pkg_parameters::NUM_REG,
    parameter int NUM_WR  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_WR-1:0]          wr_en,
    input  logic [NUM_WR-1:0][AW-1:0]  wr_addr,
    input  logic                       alloc_en,
    input  logic [AW-1:0]              alloc_addr,
    input  logic                       flush,
    output logic [NUM_REG-1:0]         busy_vec
);

    logic [NUM_REG-1:0] busy_q;
    logic [NUM_REG-1:0] busy_d;

    // Next pending state; later assignments override earlier ones.
    always_comb begin
        // NOTE: default first so every path assigns busy_d and no latch is inferred.
        busy_d = busy_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j]) begin
                busy_d[wr_addr[j]] = 1'b0;
            end
        end
        if (alloc_en) begin
            busy_d[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    // Pending-bit register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for all sequential state.
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-ported register file with a pending-write scoreboard.
// x0 always reads as 0 and is never busy. When the highest-indexed write
// ports collide on one register, the highest index wins.
// Optional macro REG_FILE_BYPASS_EN: same-cycle write data is forwarded to
// matching reads; without it, reads see only stored state.
module reg_file_sb #(
    parameter int XLEN    = pkg_parameters::XLEN,
    parameter int NUM_REG = pkg_parameters::NUM_REG,
    parameter int NUM_RD  = 3,
    parameter int NUM_WR  = 2
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_RD-1:0][pkg_parameters::AW-1:0] rs_addr,
    output logic [NUM_RD-1:0][XLEN-1:0]              rs_data,
    output logic [NUM_RD-1:0]                        rs_busy,
    input  logic [NUM_WR-1:0]                        wr_en,
    input  logic [NUM_WR-1:0][pkg_parameters::AW-1:0] wr_addr,
    input  logic [NUM_WR-1:0][XLEN-1:0]              wr_data,
    input  logic                                     alloc_en,
    input  logic [pkg_parameters::AW-1:0]            alloc_addr,
    input  logic                                     flush,
    output logic [NUM_REG-1:0]                       busy_vec
);

    typedef pkg_parameters::reg_addr_t reg_addr_t;

    logic [NUM_REG-1:0][XLEN-1:0] regs_q;
    logic [NUM_REG-1:0][XLEN-1:0] regs_d;

    reg_scoreboard #(
        .NUM_REG (NUM_REG),
        .NUM_WR  (NUM_WR)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    // Next register contents; ascending port order lets the highest port win.
    always_comb begin
        regs_d = regs_q;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wr_addr[j] != '0)) begin
                regs_d[wr_addr[j]] = wr_data[j];
            end
        end
        regs_d[0] = '0;
    end

    // Register array with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: the whole array is reset because reads after reset must return 0.
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    // Combinational read ports, with optional same-cycle write forwarding.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rs_data[i] = regs_q[rs_addr[i]];
            rs_busy[i] = busy_vec[rs_addr[i]];
`ifdef REG_FILE_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en[j] && (wr_addr[j] == rs_addr[i])) begin
                    rs_data[i] = wr_data[j];
                    rs_busy[i] = alloc_en && (alloc_addr == rs_addr[i]);
                end
            end
`endif
            if (rs_addr[i] == reg_addr_t'(0)) begin
                rs_data[i] = '0;
                rs_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed testbench for reg_file_sb; works with or without REG_FILE_BYPASS_EN.
module tb_reg_file_sb;

    localparam int XLEN    = 32;
    localparam int NUM_REG = 32;
    localparam int NUM_RD  = 3;
    localparam int NUM_WR  = 2;
    localparam int AW      = 5;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                          clk;
    logic                          rst;
    logic [NUM_RD-1:0][AW-1:0]     rs_addr;
    logic [NUM_RD-1:0][XLEN-1:0]   rs_data;
    logic [NUM_RD-1:0]             rs_busy;
    logic [NUM_WR-1:0]             wr_en;
    logic [NUM_WR-1:0][AW-1:0]     wr_addr;
    logic [NUM_WR-1:0][XLEN-1:0]   wr_data;
    logic                          alloc_en;
    logic [AW-1:0]                 alloc_addr;
    logic                          flush;
    logic [NUM_REG-1:0]            busy_vec;

    int checks;
    int errors;

    reg_file_sb #(
        .XLEN    (XLEN),
        .NUM_REG (NUM_REG),
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rs_addr    (rs_addr),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .flush      (flush),
        .busy_vec   (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = '0;
        wr_addr  = '0;
        wr_data  = '0;
        alloc_en = 1'b0;
        alloc_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        // Reset must override a write, alloc and flush in the same cycle.
        rst = 1'b1;
        wr_en = 2'b01; wr_addr[0] = 5'd4; wr_data[0] = 32'hAAAA_5555;
        alloc_en = 1'b1; alloc_addr = 5'd4;
        tick();
        tick();
        rst = 1'b0;
        idle();
        #1;
        for (int a = 0; a < NUM_REG; a++) begin
            rs_addr[0] = AW'(a);
            rs_addr[1] = AW'(NUM_REG - 1 - a);
            rs_addr[2] = AW'(a);
            #1;
            checks++;
            if (rs_data[0] !== 32'h0 || rs_data[1] !== 32'h0 || rs_busy !== 3'b000) begin
                errors++;
                $display("FAIL reset_read addr=%0d data0=%h data1=%h busy=%b expected 0", a, rs_data[0], rs_data[1], rs_busy);
            end
        end
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL reset_busy_vec got=%h expected=0", busy_vec);
        end
    endtask

    task automatic test_write_priority();
        wr_en = 2'b11;
        wr_addr[0] = 5'd5; wr_data[0] = 32'hDEAD_BEEF;
        wr_addr[1] = 5'd5; wr_data[1] = 32'h1234_5678;
        rs_addr[0] = 5'd5;
        #1;
        checks++;
        if (rs_data[0] !== (BYPASS ? 32'h1234_5678 : 32'h0)) begin
            errors++;
            $display("FAIL same_cycle_x5 got=%h expected=%h", rs_data[0], BYPASS ? 32'h1234_5678 : 32'h0);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data[0] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL write_priority_x5 got=%h expected=12345678", rs_data[0]);
        end
        // Independent writes on both ports, then read three registers at once.
        wr_en = 2'b11;
        wr_addr[0] = 5'd10; wr_data[0] = 32'h0000_0111;
        wr_addr[1] = 5'd11; wr_data[1] = 32'h0000_0222;
        tick();
        idle();
        rs_addr[0] = 5'd10; rs_addr[1] = 5'd11; rs_addr[2] = 5'd5;
        #1;
        checks++;
        if (rs_data[0] !== 32'h111 || rs_data[1] !== 32'h222 || rs_data[2] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL multi_port_read got=%h/%h/%h expected=111/222/12345678", rs_data[0], rs_data[1], rs_data[2]);
        end
    endtask

    task automatic test_alloc_then_write();
        alloc_en = 1'b1; alloc_addr = 5'd7;
        tick();
        idle();
        rs_addr[0] = 5'd7;
        #1;
        checks++;
        if (busy_vec[7] !== 1'b1 || rs_busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL alloc_x7_c1 busy_vec7=%b rs_busy=%b expected 1/1", busy_vec[7], rs_busy[0]);
        end
        tick();
        checks++;
        if (busy_vec !== 32'h0000_0080) begin
            errors++;
            $display("FAIL alloc_x7_c2 busy_vec=%h expected=00000080", busy_vec);
        end
        wr_en = 2'b01; wr_addr[0] = 5'd7; wr_data[0] = 32'h0000_00A5;
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec[7] !== 1'b0 || rs_busy[0] !== 1'b0 || rs_data[0] !== 32'hA5) begin
            errors++;
            $display("FAIL write_clears_x7 busy=%b rs_busy=%b data=%h expected 0/0/a5", busy_vec[7], rs_busy[0], rs_data[0]);
        end
    endtask

    task automatic test_alloc_write_same();
        alloc_en = 1'b1; alloc_addr = 5'd9;
        wr_en = 2'b10; wr_addr[1] = 5'd9; wr_data[1] = 32'h0000_CAFE;
        tick();
        idle();
        rs_addr[1] = 5'd9;
        #1;
        checks++;
        if (busy_vec !== 32'h0000_0200 || rs_data[1] !== 32'hCAFE || rs_busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL alloc_wins_x9 busy_vec=%h data=%h rs_busy=%b expected 00000200/cafe/1", busy_vec, rs_data[1], rs_busy[1]);
        end
    endtask

    task automatic test_x0();
        wr_en = 2'b11;
        wr_addr[0] = 5'd0; wr_data[0] = 32'hFFFF_FFFF;
        wr_addr[1] = 5'd0; wr_data[1] = 32'hFFFF_FFFF;
        alloc_en = 1'b1; alloc_addr = 5'd0;
        rs_addr[2] = 5'd0;
        #1;
        checks++;
        if (rs_data[2] !== 32'h0 || rs_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL x0_same_cycle data=%h busy=%b expected 0/0", rs_data[2], rs_busy[2]);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data[2] !== 32'h0 || rs_busy[2] !== 1'b0 || busy_vec !== 32'h0000_0200) begin
            errors++;
            $display("FAIL x0_after data=%h busy=%b busy_vec=%h expected 0/0/00000200", rs_data[2], rs_busy[2], busy_vec);
        end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        alloc_en = 1'b1; alloc_addr = 5'd12;
        wr_en = 2'b01; wr_addr[0] = 5'd13; wr_data[0] = 32'h0000_0077;
        tick();
        idle();
        rs_addr[0] = 5'd13; rs_addr[1] = 5'd9; rs_addr[2] = 5'd12;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || rs_data[0] !== 32'h77 || rs_data[1] !== 32'hCAFE || rs_busy !== 3'b000) begin
            errors++;
            $display("FAIL flush busy_vec=%h x13=%h x9=%h rs_busy=%b expected 0/77/cafe/000", busy_vec, rs_data[0], rs_data[1], rs_busy);
        end
    endtask

    task automatic test_alloc_already_busy();
        alloc_en = 1'b1; alloc_addr = 5'd14;
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0000_4000) begin
            errors++;
            $display("FAIL realloc_x14 busy_vec=%h expected=00004000", busy_vec);
        end
        wr_en = 2'b10; wr_addr[1] = 5'd14; wr_data[1] = 32'h0000_0014;
        tick();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL clear_x14 busy_vec=%h expected=0", busy_vec);
        end
    endtask

    task automatic test_bypass();
        wr_en = 2'b10; wr_addr[1] = 5'd3; wr_data[1] = 32'h0000_0055;
        rs_addr[2] = 5'd3;
        #1;
        checks++;
        if (rs_data[2] !== (BYPASS ? 32'h55 : 32'h0) || rs_busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL bypass_x3 data=%h busy=%b expected %h/0", rs_data[2], rs_busy[2], BYPASS ? 32'h55 : 32'h0);
        end
        tick();
        // Write plus alloc of the same register: a forwarded read stays busy.
        wr_data[1] = 32'h0000_0066;
        alloc_en = 1'b1; alloc_addr = 5'd3;
        #1;
        checks++;
        if (rs_data[2] !== (BYPASS ? 32'h66 : 32'h55) || rs_busy[2] !== BYPASS) begin
            errors++;
            $display("FAIL bypass_alloc_x3 data=%h busy=%b expected %h/%b", rs_data[2], rs_busy[2], BYPASS ? 32'h66 : 32'h55, BYPASS);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs_data[2] !== 32'h66 || busy_vec !== 32'h0000_0008) begin
            errors++;
            $display("FAIL after_alloc_x3 data=%h busy_vec=%h expected 66/00000008", rs_data[2], busy_vec);
        end
    endtask

    task automatic test_reset_midrun();
        rst = 1'b1;
        wr_en = 2'b01; wr_addr[0] = 5'd13; wr_data[0] = 32'h0000_1234;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        rs_addr[0] = 5'd13; rs_addr[1] = 5'd5; rs_addr[2] = 5'd3;
        #1;
        checks++;
        if (rs_data !== '0 || rs_busy !== 3'b000 || busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset data=%h busy=%b busy_vec=%h expected all 0", rs_data, rs_busy, busy_vec);
        end
        // First edge after reset release accepts a write.
        wr_en = 2'b01; wr_addr[0] = 5'd5; wr_data[0] = 32'h0000_BEEF;
        tick();
        idle();
        #1;
        checks++;
        if (rs_data[1] !== 32'hBEEF) begin
            errors++;
            $display("FAIL write_after_reset got=%h expected=beef", rs_data[1]);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        rs_addr = '0;
        idle();
        test_reset();
        test_write_priority();
        test_alloc_then_write();
        test_alloc_write_same();
        test_x0();
        test_flush();
        test_alloc_already_busy();
        test_bypass();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
